reg_bus_initiator: RTL

Command-driven REG_BUS master that drives transactions into REG_BUS responders such as the AES register-window wrappers. Callers such as a boot sequencer, a debug bridge or a test driver push write/read commands into a small FIFO. The block issues them one at a time on REG_BUS, waits for `ready` with a bounded timeout, and returns each result on a response handshake. One transaction is outstanding at a time, and commands are issued in order.

---
 rtl/reg_bus_initiator_pkg.sv | 17 +
 rtl/reg_bus_initiator_if.sv | 26 ++
 rtl/reg_bus_cmd_fifo.sv | 49 ++++
 rtl/reg_bus_initiator.sv | 124 ++++++++++++
 4 files changed

// File: rtl/reg_bus_initiator_pkg.sv
// Shared FSM encoding for the REG_BUS command initiator.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package reg_bus_initiator_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RSP  = 2'd2
    } state_e;

    // Plain-vector state codes so the FSM register stays a logic vector.
    localparam logic [1:0] ST_IDLE = 2'(IDLE);
    localparam logic [1:0] ST_REQ  = 2'(REQ);
    localparam logic [1:0] ST_RSP  = 2'(RSP);

endpackage

// File: rtl/reg_bus_initiator_if.sv
// REG_BUS request/response wires between one master and one responder.
// Latency: n/a (wires only).
// Backpressure: responder holds ready low to stretch a valid request.
interface reg_bus_initiator_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) ();
    logic [ADDR_WIDTH-1:0]   addr;
    logic                    write;
    logic [DATA_WIDTH-1:0]   wdata;
    logic [DATA_WIDTH/8-1:0] wstrb;
    logic                    valid;
    logic [DATA_WIDTH-1:0]   rdata;
    logic                    error;
    logic                    ready;

    modport master (
        output addr, write, wdata, wstrb, valid,
        input  rdata, error, ready
    );

    modport slave (
        input  addr, write, wdata, wstrb, valid,
        output rdata, error, ready
    );
endinterface

// File: rtl/reg_bus_cmd_fifo.sv
// Synchronous command FIFO, DEPTH entries of WIDTH bits.
// Latency: a push is visible at the head one cycle later; no pass-through.
// Backpressure: push ignored while full, pop ignored while empty.
module reg_bus_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    input  logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr_q;
    logic [PW-1:0]    rd_ptr_q;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full from empty when the index bits match.
    assign full    = (wr_ptr_q[PW-1] != rd_ptr_q[PW-1]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign do_push = push_vld && !full;
    assign do_pop  = pop_vld && !empty;
    assign pop_dat = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; wrap-around is plain overflow of the PW-bit counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents are don't-care once the pointers are reset.
    always_ff @(posedge clk_i) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= push_dat;
    end
endmodule

// File: rtl/reg_bus_initiator.sv
// Queues write/read commands and issues them one at a time on REG_BUS.
// Latency: push to valid >= 2 cycles; response one cycle after ready or timeout.
// Backpressure: cmd_ready_o low while FIFO full; response held until rsp_ready_i.
module reg_bus_initiator
    import reg_bus_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    cmd_valid_i,
    output logic                    cmd_ready_o,
    input  logic                    cmd_write_i,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr_i,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata_i,
    input  logic [DATA_WIDTH/8-1:0] cmd_wstrb_i,
    output logic                    rsp_valid_o,
    input  logic                    rsp_ready_i,
    output logic [DATA_WIDTH-1:0]   rsp_rdata_o,
    output logic                    rsp_error_o,
    output logic                    rsp_timeout_o,
    reg_bus_initiator_if.master     reg_bus_io
);
    typedef struct packed {
        logic                    write;
        logic [ADDR_WIDTH-1:0]   addr;
        logic [DATA_WIDTH-1:0]   wdata;
        logic [DATA_WIDTH/8-1:0] wstrb;
    } cmd_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

    cmd_t                  push_cmd;
    cmd_t                  head_cmd;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  fifo_pop;

    logic [1:0]            state_q;
    cmd_t                  req_q;
    logic [15:0]           tmo_cnt_q;
    logic [DATA_WIDTH-1:0] rsp_rdata_q;
    logic                  rsp_error_q;
    logic                  rsp_timeout_q;

    assign push_cmd = '{write: cmd_write_i, addr: cmd_addr_i,
                        wdata: cmd_wdata_i, wstrb: cmd_wstrb_i};
    assign cmd_ready_o = !fifo_full;
    assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;

    reg_bus_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(cmd_t))
    ) u_cmd_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .push_vld (cmd_valid_i),
        .push_dat (push_cmd),
        .pop_vld  (fifo_pop),
        .pop_dat  (head_cmd),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Bus request fields come straight from the request register so they
    // stay stable for the whole REQ period.
    assign reg_bus_io.valid = (state_q == ST_REQ);
    assign reg_bus_io.write = req_q.write;
    assign reg_bus_io.addr  = req_q.addr;
    assign reg_bus_io.wdata = req_q.wdata;
    assign reg_bus_io.wstrb = req_q.wstrb;

    assign rsp_valid_o   = (state_q == ST_RSP);
    assign rsp_rdata_o   = rsp_rdata_q;
    assign rsp_error_o   = rsp_error_q;
    assign rsp_timeout_o = rsp_timeout_q;

    // FSM: pop a command, hold it on the bus until ready or timeout, then
    // present the result until the caller takes it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= ST_IDLE;
            req_q         <= '0;
            tmo_cnt_q     <= '0;
            rsp_rdata_q   <= '0;
            rsp_error_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        req_q       <= head_cmd;
                        // Reads never present byte enables on the bus.
                        if (!head_cmd.write) req_q.wstrb <= '0;
                        tmo_cnt_q   <= '0;
                        state_q     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (reg_bus_io.ready) begin
                        rsp_rdata_q   <= req_q.write ? '0 : reg_bus_io.rdata;
                        rsp_error_q   <= reg_bus_io.error;
                        rsp_timeout_q <= 1'b0;
                        state_q       <= ST_RSP;
                    end else if (tmo_cnt_q == TMO_LAST) begin
                        rsp_rdata_q   <= '0;
                        rsp_error_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= ST_RSP;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 16'd1;
                    end
                end
                ST_RSP: begin
                    if (rsp_ready_i) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end
endmodule
